bnn_conv_kxk: RTL and testbench
===============================

Name: bnn_conv_kxk

Overview:
Parametrised binary (XNOR/popcount) KxK convolution core with CIN packed input channels per pixel. It consumes one window column per accepted beat from the upstream line-buffer/sliding-window block and holds a serially loaded KxK×CIN weight kernel. Each output is a signed ±1 dot product plus a thresholded sign bit, passed to the pooling/next-layer stage. This generation adds runtime image size, stall-tolerant input, thresholding and frame-done tracking.

Parameters:
K, 3, kernel side length (2..7)
CIN, 1, input channels packed per pixel (1..16)
MAX_DIM, 28, maximum image width/height supported by the counters
N (derived, not overridable), K*K*CIN, number of bits in the dot product
SW (derived), $clog2(N+1)+1, signed sum width (5 at the defaults)

Ports:
clk  in  1  clock; all logic on the rising edge
rstn  in  1  asynchronous active-low reset
cfg_width  in  8  image width in pixels, K..MAX_DIM, sampled on frame_start
cfg_height  in  8  image height in pixels, K..MAX_DIM, sampled on frame_start
wt_clear  in  1  clears the kernel and the load index
wt_valid  in  1  weight bit strobe
wt_bit  in  1  weight bit (1 = +1, 0 = -1)
wt_loaded  out  1  high once N bits are loaded
frame_start  in  1  pulse marking a new frame; may coincide with the first col_valid
col_valid  in  1  column beat valid
col_data  in  K*CIN  one window column; row r, channel ch at bit r*CIN+ch
thresh  in  SW  signed threshold for dout_bit
dout  out  SW  signed conv sum
dout_bit  out  1  binarised output: dout >= thresh
dout_valid  out  1  dout/dout_bit valid, single-cycle per output
frame_done  out  1  one-cycle pulse coincident with the last dout_valid of a frame

Behaviour:
- Reset (rstn low, async): kernel = 0, load index = 0, wt_loaded = 0, window = 0, counters = 0, all pipeline valids = 0, dout = 0, dout_bit = 0, dout_valid = 0, frame_done = 0. Reset mid-frame or mid-load discards everything; the kernel must be reloaded.
- Weight load: each wt_valid cycle writes wt_bit to index idx = (r*K+c)*CIN+ch, where c=0 is the oldest window column. idx then increments. When idx reaches N, wt_loaded is set and further wt_valid is ignored. wt_clear has priority over wt_valid in the same cycle: it zeroes the kernel, idx and wt_loaded.
- Input acceptance: a beat is accepted when col_valid & wt_loaded. col_valid while !wt_loaded is dropped, with no counter or window change. Gaps in col_valid are allowed with no limit; the window and counters simply hold.
- frame_start: latches cfg_width/cfg_height and zeroes col_idx, row_idx and the window. If col_valid is also high that cycle, the beat is accepted as column 0 of row 0.
- Window: on an accepted beat the window shifts by one column, and col_data becomes column K-1 (newest).
- Counters: col_idx 0..W-1 wraps to 0 and increments row_idx. row_idx counts output rows 0..H-K. Upstream delivers exactly H-K+1 rows of W columns per frame.
- Window valid: an accepted beat with col_idx >= K-1 launches a compute. That gives W-K+1 outputs per row and (W-K+1)*(H-K+1) per frame. The window is not cleared at row wrap; the col_idx gating masks the stale columns.
- Pipeline, free-running with no backpressure; each stage carries its own valid:
  - S1 registers the N XNOR bits of window and kernel.
  - S2 registers the popcount P (0..N).
  - S3 registers dout = 2P-N (signed SW bits, cannot overflow), dout_bit and dout_valid.
- Latency: dout_valid is asserted exactly 3 cycles after the launching beat. Back-to-back beats give back-to-back outputs.
- frame_done: asserted in the same cycle as the dout_valid for row_idx=H-K, col_idx=W-1. After it, counters idle until the next frame_start. Beats arriving after the last output and before frame_start are dropped.
- frame_start mid-frame aborts the frame with no frame_done. Computes already in flight still emerge from the pipeline.
- wt_clear during streaming: beats are dropped from that cycle on, and in-flight results complete using the kernel captured in S1.

Test Plan:
- Defaults, kernel all 1, W=H=5, all col_data=3'b111 -> 9 outputs, each dout=+9, dout_bit=1 with thresh=0; frame_done on the 9th.
- Same kernel, all-zero input -> dout=-9 for all 9 outputs; thresh=-9 gives dout_bit=1, thresh=-8 gives dout_bit=0.
- Kernel with only idx 0 = 1, random input, compared against a reference model -> dout=2*popcount(xnor)-9 for every window; launch-to-dout_valid = 3 cycles.
- Random 0-5 cycle gaps in col_valid, W=28, H=28 -> exactly 676 outputs, identical to the gap-free run; exactly one frame_done.
- K=5, CIN=4 build (N=100, SW=8), all-match window -> dout=+100; all-mismatch -> -100.
- Reset asserted mid-frame, then col_valid with no reload -> no dout_valid and wt_loaded=0. Load 8 of 9 bits -> wt_loaded stays 0. wt_clear together with wt_valid -> idx stays 0.

Source files
------------

// File: rtl/bnn_conv_kxk.sv
// Binary KxK convolution core: XNOR of a sliding window against a serially
// loaded kernel, popcount, then signed +/-1 sum and thresholded sign bit.
module bnn_conv_kxk #(
    parameter  int K       = 3,
    parameter  int CIN     = 1,
    parameter  int MAX_DIM = 28,
    localparam int N       = K * K * CIN,
    localparam int SW      = $clog2(N + 1) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           cfg_width,
    input  logic [7:0]           cfg_height,
    input  logic                 wt_clear,
    input  logic                 wt_valid,
    input  logic                 wt_bit,
    output logic                 wt_loaded,
    input  logic                 frame_start,
    input  logic                 col_valid,
    input  logic [K*CIN-1:0]     col_data,
    input  logic signed [SW-1:0] thresh,
    output logic signed [SW-1:0] dout,
    output logic                 dout_bit,
    output logic                 dout_valid,
    output logic                 frame_done
);

    localparam int IW = $clog2(N + 1);
    localparam int CW = $clog2(MAX_DIM + 1);
    localparam logic [CW-1:0] KM1_C = CW'(K - 1);
    localparam logic [CW-1:0] K_C   = CW'(K);

    // Kernel and load index
    logic [N-1:0]  kern_q, kern_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          loaded_q, loaded_d;

    // Window (column 0 oldest) and frame counters
    logic [K-1:0][K*CIN-1:0] cols_q, cols_d;
    logic [CW-1:0] col_idx_q, col_idx_d, row_idx_q, row_idx_d;
    logic [CW-1:0] width_q, width_d, height_q, height_d;
    logic          active_q, active_d;

    // Pipeline stages
    logic [N-1:0]         xnor_q, xnor_d;
    logic                 v1_q, last1_q;
    logic [IW-1:0]        pop_q, pop_d;
    logic                 v2_q, last2_q;
    logic signed [SW-1:0] dout_q, dout_d;
    logic                 dout_bit_q, dout_bit_d;
    logic                 dout_valid_q, frame_done_q;

    logic [CW-1:0] col_cur, row_cur, w_cur, h_cur;
    logic          act_cur, accept, launch, last;
    logic [N-1:0]  win_flat;

    always_comb begin
        kern_d   = kern_q;
        idx_d    = idx_q;
        loaded_d = loaded_q;
        if (wt_clear) begin
            kern_d   = '0;
            idx_d    = '0;
            loaded_d = 1'b0;
        end else if (wt_valid && !loaded_q) begin
            kern_d[idx_q] = wt_bit;
            idx_d         = idx_q + IW'(1);
            loaded_d      = (idx_q + IW'(1) == IW'(N));
        end
    end

    // frame_start restarts the frame in the same cycle it may deliver column 0
    always_comb begin
        col_cur = frame_start ? '0 : col_idx_q;
        row_cur = frame_start ? '0 : row_idx_q;
        w_cur   = frame_start ? CW'(cfg_width) : width_q;
        h_cur   = frame_start ? CW'(cfg_height) : height_q;
        act_cur = frame_start | active_q;
        accept  = col_valid & loaded_q & ~wt_clear & act_cur;
        launch  = accept && (col_cur >= KM1_C);
        last    = launch && (col_cur == w_cur - CW'(1)) && (row_cur == h_cur - K_C);

        col_idx_d = col_cur;
        row_idx_d = row_cur;
        width_d   = w_cur;
        height_d  = h_cur;
        active_d  = act_cur;
        cols_d    = frame_start ? '0 : cols_q;
        if (accept) begin
            for (int c = 0; c < K - 1; c++) begin
                cols_d[c] = frame_start ? '0 : cols_q[c+1];
            end
            cols_d[K-1] = col_data;
            if (col_cur == w_cur - CW'(1)) begin
                col_idx_d = '0;
                row_idx_d = row_cur + CW'(1);
            end else begin
                col_idx_d = col_cur + CW'(1);
            end
            if (last) begin
                active_d = 1'b0;
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                for (int ch = 0; ch < CIN; ch++) begin
                    win_flat[(r*K+c)*CIN+ch] = cols_d[c][r*CIN+ch];
                end
            end
        end
        xnor_d = ~(win_flat ^ kern_q);
    end

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < N; i++) begin
            pop_d = pop_d + IW'(xnor_q[i]);
        end
    end

    // 2P-N computed modulo 2^SW; the true result always fits in SW signed bits
    always_comb begin
        dout_d     = $signed({pop_q, 1'b0}) - $signed(SW'(N));
        dout_bit_d = (dout_d >= thresh);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            kern_q       <= '0;
            idx_q        <= '0;
            loaded_q     <= 1'b0;
            cols_q       <= '0;
            col_idx_q    <= '0;
            row_idx_q    <= '0;
            width_q      <= '0;
            height_q     <= '0;
            active_q     <= 1'b0;
            xnor_q       <= '0;
            v1_q         <= 1'b0;
            last1_q      <= 1'b0;
            pop_q        <= '0;
            v2_q         <= 1'b0;
            last2_q      <= 1'b0;
            dout_q       <= '0;
            dout_bit_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            kern_q       <= kern_d;
            idx_q        <= idx_d;
            loaded_q     <= loaded_d;
            cols_q       <= cols_d;
            col_idx_q    <= col_idx_d;
            row_idx_q    <= row_idx_d;
            width_q      <= width_d;
            height_q     <= height_d;
            active_q     <= active_d;
            xnor_q       <= xnor_d;
            v1_q         <= launch;
            last1_q      <= last;
            pop_q        <= pop_d;
            v2_q         <= v1_q;
            last2_q      <= last1_q;
            dout_q       <= dout_d;
            dout_bit_q   <= dout_bit_d;
            dout_valid_q <= v2_q;
            frame_done_q <= last2_q;
        end
    end

    assign wt_loaded  = loaded_q;
    assign dout       = dout_q;
    assign dout_bit   = dout_bit_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bnn_conv_kxk.sv
// Bench for bnn_conv_kxk: window-level reference model with an expected queue,
// plus a K=5/CIN=4 instance for the wide-sum extremes.
module tb_bnn_conv_kxk;
    localparam int K = 3, CIN = 1, N = 9, SW = 5;

    logic clk = 1'b0;
    logic rstn;
    logic [7:0] cfg_width, cfg_height;
    logic wt_clear, wt_valid, wt_bit, wt_loaded;
    logic frame_start, col_valid;
    logic [K*CIN-1:0] col_data;
    logic signed [SW-1:0] thresh, dout;
    logic dout_bit, dout_valid, frame_done;

    logic k5_wt_clear, k5_wt_valid, k5_wt_bit, k5_wt_loaded;
    logic k5_frame_start, k5_col_valid;
    logic [19:0] k5_col_data;
    logic signed [7:0] k5_thresh, k5_dout;
    logic k5_dout_bit, k5_dout_valid, k5_frame_done;

    bnn_conv_kxk #(.K(3), .CIN(1), .MAX_DIM(28)) dut (
        .clk(clk), .rstn(rstn), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .wt_clear(wt_clear), .wt_valid(wt_valid), .wt_bit(wt_bit), .wt_loaded(wt_loaded),
        .frame_start(frame_start), .col_valid(col_valid), .col_data(col_data),
        .thresh(thresh), .dout(dout), .dout_bit(dout_bit), .dout_valid(dout_valid),
        .frame_done(frame_done)
    );

    bnn_conv_kxk #(.K(5), .CIN(4), .MAX_DIM(28)) dut_k5 (
        .clk(clk), .rstn(rstn), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .wt_clear(k5_wt_clear), .wt_valid(k5_wt_valid), .wt_bit(k5_wt_bit),
        .wt_loaded(k5_wt_loaded), .frame_start(k5_frame_start), .col_valid(k5_col_valid),
        .col_data(k5_col_data), .thresh(k5_thresh), .dout(k5_dout), .dout_bit(k5_dout_bit),
        .dout_valid(k5_dout_valid), .frame_done(k5_frame_done)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    int out_cnt = 0, fd_cnt = 0, last_dout = 0, last_bit = 0, rec_sel = 0;
    int ref_q[$], gap_q[$];

    // reference model state
    logic           kern_m [0:N-1];
    int             m_idx = 0;
    logic           m_loaded = 1'b0;
    logic [K*CIN-1:0] beats [0:27][0:27];
    logic [SW:0]    exp_q[$];
    int             due_q[$];

    task automatic chk(input string nm, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) kern_m[i] = 1'b0;
        m_idx = 0;
        m_loaded = 1'b0;
        exp_q.delete();
        due_q.delete();
    endtask

    function automatic int model_dot(input int ro, input int co);
        int s = 0;
        logic [K*CIN-1:0] colv;
        for (int c = 0; c < K; c++) begin
            colv = beats[ro][co-K+1+c];
            for (int r = 0; r < K; r++)
                for (int ch = 0; ch < CIN; ch++)
                    s += (colv[r*CIN+ch] == kern_m[(r*K+c)*CIN+ch]) ? 1 : -1;
        end
        return s;
    endfunction

    // driver tasks
    task automatic load_bit(input logic b, input logic clr);
        wt_valid = 1'b1; wt_bit = b; wt_clear = clr;
        if (clr) begin
            for (int i = 0; i < N; i++) kern_m[i] = 1'b0;
            m_idx = 0; m_loaded = 1'b0;
        end else if (!m_loaded) begin
            kern_m[m_idx] = b;
            m_idx++;
            m_loaded = (m_idx == N);
        end
        @(posedge clk); #1;
        wt_valid = 1'b0; wt_clear = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                beats[r][c] = (mode == 0) ? 3'b111 : (mode == 1) ? 3'b000 : 3'($urandom_range(0, 7));
    endtask

    task automatic run_frame(input int w, input int h, input int maxgap);
        logic signed [SW-1:0] d;
        cfg_width = 8'(w); cfg_height = 8'(h);
        for (int ro = 0; ro <= h - K; ro++) begin
            for (int co = 0; co < w; co++) begin
                repeat ($urandom_range(0, maxgap)) begin
                    @(posedge clk); #1;
                end
                frame_start = (ro == 0 && co == 0);
                col_valid = 1'b1;
                col_data = beats[ro][co];
                if (m_loaded && co >= K - 1) begin
                    d = SW'(model_dot(ro, co));
                    exp_q.push_back({(ro == h - K && co == w - 1), d});
                    due_q.push_back(cyc + 3);
                end
                @(posedge clk); #1;
                frame_start = 1'b0; col_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic k5_frame(input logic [19:0] d, input int exp_d, input int exp_b);
        bit got = 0;
        for (int co = 0; co < 5; co++) begin
            k5_frame_start = (co == 0); k5_col_valid = 1'b1; k5_col_data = d;
            @(posedge clk); #1;
        end
        k5_frame_start = 1'b0; k5_col_valid = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (k5_dout_valid) begin
                got = 1;
                chk("k5_dout", k5_dout, exp_d);
                chk("k5_dout_bit", k5_dout_bit, exp_b);
                chk("k5_frame_done", k5_frame_done, 1);
            end
        end
        chk("k5_output_seen", got, 1);
        @(posedge clk); #1;
    endtask

    // scoreboard: compare every cycle against the expected queue
    always @(negedge clk) begin
        logic [SW:0] e;
        if (rstn) begin
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dout_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc, due_q.pop_front());
                    chk("dout", dout, $signed(e[SW-1:0]));
                    chk("dout_bit", dout_bit, ($signed(e[SW-1:0]) >= thresh) ? 1 : 0);
                    chk("frame_done", frame_done, e[SW]);
                end
                out_cnt++;
                last_dout = dout;
                last_bit = dout_bit;
                if (rec_sel == 1) ref_q.push_back(int'(dout));
                if (rec_sel == 2) gap_q.push_back(int'(dout));
            end else begin
                chk("frame_done_without_valid", frame_done, 0);
                if (due_q.size() > 0 && due_q[0] < cyc) begin
                    chk("missing_dout_valid", 0, 1);
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
            end
            if (frame_done) fd_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, fdb, mism;
        rstn = 1'b0;
        cfg_width = 8'd5; cfg_height = 8'd5;
        wt_clear = 0; wt_valid = 0; wt_bit = 0; frame_start = 0; col_valid = 0; col_data = '0;
        thresh = '0;
        k5_wt_clear = 0; k5_wt_valid = 0; k5_wt_bit = 0; k5_frame_start = 0;
        k5_col_valid = 0; k5_col_data = '0; k5_thresh = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wt_loaded", wt_loaded, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_bit", dout_bit, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // K=5, CIN=4: all-match and all-mismatch windows
        for (int i = 0; i < 100; i++) begin
            k5_wt_valid = 1'b1; k5_wt_bit = 1'b1;
            @(posedge clk); #1;
        end
        k5_wt_valid = 1'b0;
        chk("k5_loaded", k5_wt_loaded, 1);
        k5_frame(20'hFFFFF, 100, 1);
        k5_frame(20'h00000, -100, 0);

        // all-ones kernel; 8 bits is not enough
        for (int i = 0; i < 8; i++) load_bit(1'b1, 1'b0);
        chk("load8_not_loaded", wt_loaded, 0);
        load_bit(1'b1, 1'b0);
        chk("load9_loaded", wt_loaded, 1);

        fill(0); thresh = 5'sd0;
        base = out_cnt; fdb = fd_cnt;
        run_frame(5, 5, 0); drain();
        chk("ones_count", out_cnt - base, 9);
        chk("ones_last_dout", last_dout, 9);
        chk("ones_last_bit", last_bit, 1);
        chk("ones_frame_done_cnt", fd_cnt - fdb, 1);

        fill(1); thresh = -5'sd9;
        base = out_cnt;
        run_frame(5, 5, 0); drain();
        chk("zeros_count", out_cnt - base, 9);
        chk("zeros_last_dout", last_dout, -9);
        chk("zeros_bit_thr_m9", last_bit, 1);
        thresh = -5'sd8;
        run_frame(5, 5, 0); drain();
        chk("zeros_bit_thr_m8", last_bit, 0);

        // clear together with a write must leave idx at 0; kernel = idx0 only
        thresh = 5'sd0;
        load_bit(1'b1, 1'b1);
        chk("clear_unloaded", wt_loaded, 0);
        load_bit(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) load_bit(1'b0, 1'b0);
        chk("clear_idx_stayed_0", wt_loaded, 0);
        load_bit(1'b0, 1'b0);
        chk("reload_loaded", wt_loaded, 1);
        fill(2);
        base = out_cnt;
        run_frame(7, 6, 0); drain();
        chk("idx0_count", out_cnt - base, 20);

        // full 28x28 frame, gap-free and then with random gaps
        fill(2);
        base = out_cnt; fdb = fd_cnt; rec_sel = 1;
        run_frame(28, 28, 0); drain();
        chk("big_count", out_cnt - base, 676);
        chk("big_frame_done_cnt", fd_cnt - fdb, 1);
        base = out_cnt; fdb = fd_cnt; rec_sel = 2;
        run_frame(28, 28, 5); drain();
        rec_sel = 0;
        chk("gap_count", out_cnt - base, 676);
        chk("gap_frame_done_cnt", fd_cnt - fdb, 1);
        mism = 0;
        for (int i = 0; i < ref_q.size() && i < gap_q.size(); i++)
            if (ref_q[i] != gap_q[i]) mism++;
        chk("gap_len_equal", gap_q.size(), ref_q.size());
        chk("gap_identical", mism, 0);

        // reset mid-frame discards in-flight work and the kernel
        fill(0);
        cfg_width = 8'd5; cfg_height = 8'd5;
        for (int co = 0; co < 4; co++) begin
            frame_start = (co == 0); col_valid = 1'b1; col_data = beats[0][co];
            @(posedge clk); #1;
        end
        frame_start = 1'b0; col_valid = 1'b0;
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("midrst_wt_loaded", wt_loaded, 0);
        base = out_cnt;
        run_frame(5, 5, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_outputs", out_cnt - base, 0);
        chk("midrst_still_unloaded", wt_loaded, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
